// File: rtl/mac_pkg.sv
// Shared defaults and FSM encoding for the multiply-accumulate datapath.
package mac_pkg;

   localparam int DATA_W_DEF  = 8;
   localparam int ACC_W_DEF   = 20;
   localparam int N_TERMS_DEF = 16;

   // N_TERMS is capped at 255, so 8-bit term counters always suffice.
   localparam int CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

endpackage

// File: rtl/kogge_stone_adder.sv
// Parallel-prefix (Kogge-Stone) adder, log2(WIDTH) prefix levels.
// Purely combinational: zero latency, no flow control.
// No backpressure: the result follows the operands in the same cycle.
module kogge_stone_adder #(
   parameter int WIDTH = 20
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] s,
   output logic             cout
);

   localparam int LVL   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int DLAST = 1 << (LVL - 1);

   logic [WIDTH-1:0] g_fin;
   logic [WIDTH-1:0] carry;

   genvar lv;
   generate
      for (lv = 0; lv < LVL; lv++) begin : stg
         logic [WIDTH-1:0] g;
         logic [WIDTH-1:0] p;
         if (lv == 0) begin : base
            // cin folds into bit 0 generate so every prefix already includes it.
            assign p = a ^ b;
            assign g = (a & b) | (p & WIDTH'(cin));
         end else begin : comb
            assign g = stg[lv-1].g | (stg[lv-1].p & (stg[lv-1].g << (1 << (lv - 1))));
            assign p = stg[lv-1].p & (stg[lv-1].p << (1 << (lv - 1)));
         end
      end
   endgenerate

   assign g_fin = stg[LVL-1].g | (stg[LVL-1].p & (stg[LVL-1].g << DLAST));
   assign carry = {g_fin[WIDTH-2:0], cin};
   assign s     = stg[0].p ^ carry;
   assign cout  = g_fin[WIDTH-1];

endmodule

// File: rtl/mac_accumulator.sv
// N-term unsigned dot product: registered 8x8 product, then prefix-adder accumulate.
// Latency: last term accepted at edge E is summed at E+1, out_valid visible after E+1.
// Backpressure: in_ready drops once N_TERMS are issued; result held in HOLD until out_ready.
module mac_accumulator
   import mac_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int ACC_W   = ACC_W_DEF,
   parameter int N_TERMS = N_TERMS_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  acc_out,
   output logic              overflow
);

   localparam int PW = 2 * DATA_W;
   localparam logic [CNT_W-1:0] N_CNT = CNT_W'(N_TERMS);

   state_t           state;
   logic [PW-1:0]    prod_r;
   logic             p_valid;
   logic [CNT_W-1:0] issued;
   logic [CNT_W-1:0] added;
   logic [ACC_W-1:0] sum;
   logic             carry;
   logic             accept;

   assign in_ready = (state == ACCUM) && (issued < N_CNT);
   assign accept   = in_valid && in_ready;

   kogge_stone_adder #(
      .WIDTH(ACC_W)
   ) u_add (
      .a    (acc_out),
      .b    (ACC_W'(prod_r)),
      .cin  (1'b0),
      .s    (sum),
      .cout (carry)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         prod_r    <= '0;
         p_valid   <= 1'b0;
         issued    <= '0;
         added     <= '0;
         acc_out   <= '0;
         overflow  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               p_valid <= 1'b0;
               if (start) begin
                  acc_out  <= '0;
                  overflow <= 1'b0;
                  issued   <= '0;
                  added    <= '0;
                  state    <= ACCUM;
               end
            end
            ACCUM: begin
               p_valid <= accept;
               if (accept) begin
                  prod_r <= PW'(a) * PW'(b);
                  issued <= issued + CNT_W'(1);
               end
               if (p_valid) begin
                  acc_out  <= sum;
                  overflow <= overflow | carry;
                  added    <= added + CNT_W'(1);
                  if (added == N_CNT - CNT_W'(1)) begin
                     state     <= HOLD;
                     out_valid <= 1'b1;
                  end
               end
            end
            HOLD: begin
               p_valid <= 1'b0;
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
               p_valid   <= 1'b0;
            end
         endcase
      end
   end

endmodule
